vco_lock_ctrl: RTL and testbench

VCO_LOCK_CTRL -- requirements
Module: vco_lock_ctrl

---
 rtl/vco_ctrl_pkg.sv | 31 +++
 rtl/vco_lock_ctrl_if.sv | 29 ++
 rtl/pd_window_acc.sv | 51 +++++
 rtl/vco_lock_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_vco_lock_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vco_ctrl_pkg.sv
// Shared types and helpers for the VCO lock controller: state encoding,
// phase-detector net width and the wide signed clamp.
package vco_ctrl_pkg;

  localparam int unsigned NET_W   = 16;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned WIDE_W  = 64;
  localparam int          NET_MAX = 32767;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SWEEP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TRACK  = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  function automatic logic signed [WIDE_W-1:0] clamp_wide(
    input logic signed [WIDE_W-1:0] x,
    input logic signed [WIDE_W-1:0] lo,
    input logic signed [WIDE_W-1:0] hi
  );
    logic signed [WIDE_W-1:0] r;
    r = x;
    if (x < lo) r = lo;
    else if (x > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/vco_lock_ctrl_if.sv
// Control/status bundle between the lock controller and its environment.
interface vco_lock_ctrl_if #(
  parameter int unsigned CTRL_W = 32
);
  import vco_ctrl_pkg::*;

  logic                     start;
  logic                     abort;
  logic                     pd_up;
  logic                     pd_dn;
  logic signed [CTRL_W-1:0] lf_ctrl;
  logic signed [CTRL_W-1:0] v_ctrl;
  logic                     lf_clear;
  logic                     lf_enable;
  logic                     locked;
  logic                     busy;
  logic                     fail;
  logic [STATE_W-1:0]       state;

  modport master (
    output start, abort, pd_up, pd_dn, lf_ctrl,
    input  v_ctrl, lf_clear, lf_enable, locked, busy, fail, state
  );

  modport slave (
    input  start, abort, pd_up, pd_dn, lf_ctrl,
    output v_ctrl, lf_clear, lf_enable, locked, busy, fail, state
  );
endinterface

// File: rtl/pd_window_acc.sv
// Window counter plus saturating signed phase-detector net accumulator;
// net already includes the current cycle's pulse so it is valid on win_end.
module pd_window_acc
  import vco_ctrl_pkg::*;
#(
  parameter int unsigned WIN_LEN = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    run,
  input  logic                    pd_up,
  input  logic                    pd_dn,
  output logic                    win_end,
  output logic signed [NET_W-1:0] net
);

  localparam int unsigned         CNT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0]    LAST   = CNT_W'(WIN_LEN - 1);
  localparam logic signed [NET_W:0] SAT_HI = (NET_W+1)'(NET_MAX);
  localparam logic signed [NET_W:0] SAT_LO = (NET_W+1)'(-NET_MAX);

  logic [CNT_W-1:0]        cnt;
  logic signed [NET_W-1:0] acc;
  logic signed [NET_W:0]   sum;

  always_comb begin
    sum = (NET_W+1)'(acc);
    if (pd_up && !pd_dn)      sum = sum + (NET_W+1)'(1);
    else if (pd_dn && !pd_up) sum = sum - (NET_W+1)'(1);
    if (sum > SAT_HI)      net = NET_W'(SAT_HI);
    else if (sum < SAT_LO) net = NET_W'(SAT_LO);
    else                   net = NET_W'(sum);
    win_end = run && (cnt == LAST);
  end

  // Window restarts at count 0 and net 0 the cycle after win_end.
  always_ff @(posedge clk) begin
    if (!rst_n || clr || !run) begin
      cnt <= '0;
      acc <= '0;
    end else if (win_end) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      acc <= net;
    end
  end

endmodule

// File: rtl/vco_lock_ctrl.sv
// VCO acquisition/lock controller: coarse sweep, settle, fine tracking through
// the loop filter, lock/unlock qualification and sweep-timeout failure.
module vco_lock_ctrl
  import vco_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W        = 32,
  parameter int unsigned WIN_LEN       = 256,
  parameter int unsigned SWEEP_STEP    = 4096,
  parameter int          V_MIN         = -1048576,
  parameter int          V_MAX         = 1048575,
  parameter int unsigned ACQ_THR       = 8,
  parameter int unsigned LOCK_THR      = 4,
  parameter int unsigned UNLOCK_THR    = 16,
  parameter int unsigned LOCK_CNT      = 4,
  parameter int unsigned UNLOCK_CNT    = 2,
  parameter int unsigned SETTLE_WIN    = 2,
  parameter int unsigned MAX_SWEEP_WIN = 1024
) (
  input logic           clk,
  input logic           rst_n,
  vco_lock_ctrl_if.slave bus
);

  localparam int unsigned SW_W = $clog2(MAX_SWEEP_WIN + 1);
  localparam int unsigned ST_W = $clog2(SETTLE_WIN + 1);
  localparam int unsigned LK_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned UL_W = $clog2(UNLOCK_CNT + 1);
  localparam logic signed [WIDE_W-1:0] V_MIN_W = WIDE_W'(V_MIN);
  localparam logic signed [WIDE_W-1:0] V_MAX_W = WIDE_W'(V_MAX);
  localparam logic signed [WIDE_W-1:0] STEP_W  = WIDE_W'(SWEEP_STEP);

  state_e                   st;
  logic signed [CTRL_W-1:0] coarse;
  logic signed [CTRL_W-1:0] coarse_next;
  logic signed [CTRL_W-1:0] track_v;
  logic signed [CTRL_W:0]   track_sum;
  logic signed [WIDE_W-1:0] stepped;
  logic [SW_W-1:0]          sweep_cnt;
  logic [ST_W-1:0]          settle_cnt;
  logic [LK_W-1:0]          lock_cnt;
  logic [UL_W-1:0]          unlock_cnt;
  logic                     win_end;
  logic signed [NET_W-1:0]  net;
  logic [NET_W-1:0]         net_abs;
  logic                     net_pos;
  logic                     net_neg;
  logic                     acc_clr;
  logic                     acc_run;

  pd_window_acc #(.WIN_LEN(WIN_LEN)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .run     (acc_run),
    .pd_up   (bus.pd_up),
    .pd_dn   (bus.pd_dn),
    .win_end (win_end),
    .net     (net)
  );

  always_comb begin
    acc_run = (st != ST_IDLE);
    acc_clr = bus.abort || (bus.start && (st == ST_IDLE || st == ST_FAIL));
    net_neg = net[NET_W-1];
    net_pos = !net_neg && (net != '0);
    net_abs = net_neg ? NET_W'(-net) : NET_W'(net);
    stepped = WIDE_W'(coarse);
    if (net_pos)      stepped = stepped + STEP_W;
    else if (net_neg) stepped = stepped - STEP_W;
    coarse_next = CTRL_W'(clamp_wide(stepped, V_MIN_W, V_MAX_W));
    // One extra bit keeps coarse + lf_ctrl exact before clamping.
    track_sum = (CTRL_W+1)'(coarse) + (CTRL_W+1)'(bus.lf_ctrl);
    track_v   = CTRL_W'(clamp_wide(WIDE_W'(track_sum), V_MIN_W, V_MAX_W));
  end

  assign bus.state = st;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.abort) begin
      st            <= ST_IDLE;
      coarse        <= '0;
      sweep_cnt     <= '0;
      settle_cnt    <= '0;
      lock_cnt      <= '0;
      unlock_cnt    <= '0;
      bus.v_ctrl    <= '0;
      bus.lf_clear  <= 1'b0;
      bus.lf_enable <= 1'b0;
      bus.locked    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.fail      <= 1'b0;
    end else begin
      bus.lf_clear <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          bus.v_ctrl <= '0;
          if (bus.start) begin
            st        <= ST_SWEEP;
            coarse    <= '0;
            sweep_cnt <= '0;
            bus.busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          bus.v_ctrl <= coarse;
          if (win_end) begin
            if (net_abs <= NET_W'(ACQ_THR)) begin
              st           <= ST_SETTLE;
              settle_cnt   <= '0;
              bus.lf_clear <= 1'b1;
            end else begin
              coarse <= coarse_next;
              if (sweep_cnt == SW_W'(MAX_SWEEP_WIN - 1)) begin
                st       <= ST_FAIL;
                bus.fail <= 1'b1;
                bus.busy <= 1'b0;
              end else begin
                sweep_cnt <= sweep_cnt + SW_W'(1);
              end
            end
          end
        end
        ST_SETTLE: begin
          bus.v_ctrl <= coarse;
          if (win_end) begin
            if (settle_cnt == ST_W'(SETTLE_WIN - 1)) begin
              st            <= ST_TRACK;
              lock_cnt      <= '0;
              bus.lf_enable <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + ST_W'(1);
            end
          end
        end
        ST_TRACK: begin
          bus.v_ctrl <= track_v;
          if (win_end) begin
            if (net_abs <= NET_W'(LOCK_THR)) begin
              if (lock_cnt == LK_W'(LOCK_CNT - 1)) begin
                st         <= ST_LOCKED;
                unlock_cnt <= '0;
                bus.locked <= 1'b1;
              end else begin
                lock_cnt <= lock_cnt + LK_W'(1);
              end
            end else begin
              lock_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          bus.v_ctrl <= track_v;
          if (win_end) begin
            if (net_abs > NET_W'(UNLOCK_THR)) begin
              if (unlock_cnt == UL_W'(UNLOCK_CNT - 1)) begin
                st            <= ST_SWEEP;
                sweep_cnt     <= '0;
                bus.locked    <= 1'b0;
                bus.lf_enable <= 1'b0;
              end else begin
                unlock_cnt <= unlock_cnt + UL_W'(1);
              end
            end else begin
              unlock_cnt <= '0;
            end
          end
        end
        ST_FAIL: begin
          if (bus.start) begin
            st        <= ST_SWEEP;
            coarse    <= '0;
            sweep_cnt <= '0;
            bus.fail  <= 1'b0;
            bus.busy  <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vco_lock_ctrl.sv
// Bench for vco_lock_ctrl: directed scenarios and randomized phase-detector
// traffic checked window-by-window against a behavioural model.
module tb_vco_lock_ctrl;

  localparam int CW    = 32;
  localparam int WL    = 16;
  localparam int STEP  = 4096;
  localparam int VMAX  = 20490;
  localparam int VMIN  = -20490;
  localparam int ACQ   = 8;
  localparam int LTHR  = 4;
  localparam int UTHR  = 15;
  localparam int LCNT  = 4;
  localparam int UCNT  = 2;
  localparam int SETW  = 2;
  localparam int MAXSW = 8;

  localparam int S_IDLE = 0, S_SWEEP = 1, S_SETTLE = 2, S_TRACK = 3, S_LOCKED = 4, S_FAIL = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vco_lock_ctrl_if #(.CTRL_W(CW)) bus ();

  vco_lock_ctrl #(
    .CTRL_W(CW), .WIN_LEN(WL), .SWEEP_STEP(STEP), .V_MIN(VMIN), .V_MAX(VMAX),
    .ACQ_THR(ACQ), .LOCK_THR(LTHR), .UNLOCK_THR(UTHR), .LOCK_CNT(LCNT),
    .UNLOCK_CNT(UCNT), .SETTLE_WIN(SETW), .MAX_SWEEP_WIN(MAXSW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int     m_state, m_sweep, m_settle, m_lock, m_unlock;
  longint m_coarse, m_v;
  bit     m_clear;

  function automatic longint clampv(input longint x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_coarse = 0; m_v = 0; m_clear = 0;
    m_sweep = 0; m_settle = 0; m_lock = 0; m_unlock = 0;
  endtask

  // Window-level reference: one call per closed window with its net count.
  task automatic model_window(input int n);
    int a;
    a = (n < 0) ? -n : n;
    m_clear = 0;
    case (m_state)
      S_SWEEP: begin
        if (a <= ACQ) begin
          m_state = S_SETTLE; m_settle = 0; m_clear = 1;
        end else begin
          m_coarse = clampv(m_coarse + ((n > 0) ? STEP : -STEP));
          m_sweep++;
          if (m_sweep >= MAXSW) m_state = S_FAIL;
        end
      end
      S_SETTLE: begin
        m_settle++;
        if (m_settle >= SETW) begin m_state = S_TRACK; m_lock = 0; end
      end
      S_TRACK: begin
        if (a <= LTHR) begin
          m_lock++;
          if (m_lock >= LCNT) begin m_state = S_LOCKED; m_unlock = 0; end
        end else m_lock = 0;
      end
      S_LOCKED: begin
        if (a > UTHR) begin
          m_unlock++;
          if (m_unlock >= UCNT) begin m_state = S_SWEEP; m_sweep = 0; end
        end else m_unlock = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_state"},  bus.state,     m_state);
    chk({tag, "_busy"},   bus.busy,      (m_state >= S_SWEEP && m_state <= S_LOCKED) ? 1 : 0);
    chk({tag, "_locked"}, bus.locked,    (m_state == S_LOCKED) ? 1 : 0);
    chk({tag, "_fail"},   bus.fail,      (m_state == S_FAIL) ? 1 : 0);
    chk({tag, "_lfen"},   bus.lf_enable, (m_state == S_TRACK || m_state == S_LOCKED) ? 1 : 0);
    chk({tag, "_lfclr"},  bus.lf_clear,  m_clear ? 1 : 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"},  bus.state,     0);
    chk({tag, "_vctrl"},  bus.v_ctrl,    0);
    chk({tag, "_lfclr"},  bus.lf_clear,  0);
    chk({tag, "_lfen"},   bus.lf_enable, 0);
    chk({tag, "_locked"}, bus.locked,    0);
    chk({tag, "_busy"},   bus.busy,      0);
    chk({tag, "_fail"},   bus.fail,      0);
  endtask

  // Drives one full measurement window; pulse probabilities are in percent.
  task automatic run_window(input int unsigned up_pct, input int unsigned dn_pct,
                            input longint lf, input bit poke_start);
    int     n;
    longint exp_v;
    n = 0;
    bus.lf_ctrl = CW'(lf);
    case (m_state)
      S_SWEEP, S_SETTLE:  exp_v = m_coarse;
      S_TRACK, S_LOCKED:  exp_v = clampv(m_coarse + lf);
      default:            exp_v = m_v;
    endcase
    for (int i = 0; i < WL; i++) begin
      bit u, d;
      u = ($urandom_range(99) < up_pct);
      d = ($urandom_range(99) < dn_pct);
      bus.pd_up = u;
      bus.pd_dn = d;
      bus.start = poke_start && (i == 5);
      if (u && !d) n++;
      else if (d && !u) n--;
      tick();
      if (i == 0) begin
        chk("v_ctrl", bus.v_ctrl, exp_v);
        chk("lf_clear_one_cycle", bus.lf_clear, 0);
      end
    end
    bus.pd_up = 1'b0;
    bus.pd_dn = 1'b0;
    bus.start = 1'b0;
    m_v = exp_v;
    model_window(n);
    check_status("win");
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (m_state == S_IDLE || m_state == S_FAIL) begin
      m_state = S_SWEEP; m_coarse = 0; m_sweep = 0;
    end
    m_clear = 0;
    check_status("start");
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    model_reset();
    check_status("abort");
    chk("abort_vctrl", bus.v_ctrl, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pd_up = 1'b0; bus.pd_dn = 1'b0;
    bus.lf_ctrl = '0;
    model_reset();
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_status("idle");

    // Coarse sweep upward three steps, then a quiet window qualifies.
    do_start();
    for (int w = 0; w < 3; w++) run_window(100, 0, 0, 1'b0);
    run_window(0, 0, 0, 1'b0);
    chk("settle_entry", bus.state, S_SETTLE);
    for (int w = 0; w < SETW; w++) run_window(0, 0, 100, 1'b0);

    // Tracking with a fixed loop-filter offset until lock; stray start ignored.
    for (int w = 0; w < LCNT; w++) run_window(0, 0, 100, (w == 1));
    chk("locked_flag", bus.locked, 1);

    // Late pulses every cycle drop lock and return to sweep at the same coarse.
    for (int w = 0; w < UCNT; w++) run_window(0, 100, 100, 1'b0);
    run_window(0, 0, 100, 1'b0);

    // Upper clamp of coarse+lf_ctrl, then lower clamp.
    do_abort();
    do_start();
    for (int w = 0; w < 5; w++) run_window(100, 0, 0, 1'b0);
    run_window(0, 0, 0, 1'b0);
    for (int w = 0; w < SETW; w++) run_window(0, 0, 0, 1'b0);
    run_window(0, 0, 1000, 1'b0);
    chk("track_vmax", bus.v_ctrl, VMAX);
    run_window(0, 0, -50000, 1'b0);

    // Abort and start together on the win_end cycle while tracking.
    for (int i = 0; i < WL - 1; i++) tick();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    model_reset();
    check_all_zero("abort_at_win_end");
    tick();
    chk("abort_stays_idle", bus.state, S_IDLE);

    // Continuous early pulses saturate coarse and exhaust the sweep budget.
    do_start();
    for (int w = 0; w < MAXSW; w++) run_window(100, 0, 0, 1'b0);
    chk("fail_flag", bus.fail, 1);
    chk("fail_vctrl", bus.v_ctrl, VMAX);
    run_window(100, 0, 0, 1'b0);
    do_start();
    run_window(0, 0, 0, 1'b0);

    // Synchronous reset in the middle of a sweep window.
    do_abort();
    do_start();
    run_window(100, 0, 0, 1'b0);
    bus.pd_up = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("reset_mid_sweep");
    rst_n = 1'b1;
    bus.pd_up = 1'b0;
    model_reset();
    tick();

    // Randomized traffic; quiet windows dominate once tracking.
    for (int t = 0; t < 6; t++) begin
      do_start();
      for (int w = 0; w < 18; w++) begin
        int unsigned up, dn;
        longint lf;
        if (m_state >= S_SETTLE && m_state <= S_LOCKED && $urandom_range(3) != 0) begin
          up = $urandom_range(10);
          dn = $urandom_range(10);
        end else begin
          up = $urandom_range(100);
          dn = $urandom_range(100);
        end
        lf = longint'($urandom_range(60000)) - 30000;
        run_window(up, dn, lf, bit'($urandom_range(1)));
      end
      do_abort();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
